// File: rtl/gemv_pkg.sv
// gemv_pkg: shared FSM states and requantisation helper for gemv_stream
package gemv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_X, STREAM_W, WAIT_Y, DONE} state_t;
  // round-half-up arithmetic right shift, then clamp to a signed dw-bit range
  function automatic logic signed [63:0] sat_rshift(input logic signed [63:0] v, input logic [4:0] sh, input int dw);
    logic signed [63:0] r, hi, lo;
    r = (v + ((64'sd1 <<< sh) >>> 1)) >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return r > hi ? hi : (r < lo ? lo : r);
  endfunction
endpackage

// File: rtl/gemv_tile_dot.sv
// gemv_tile_dot: masked TILE_SIZE-lane signed dot product, sum registered one cycle after the beat
module gemv_tile_dot #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int TILE_SIZE = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  x,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  w,
  input  logic [TILE_SIZE-1:0]                  mask,
  output logic                                  out_valid,
  output logic signed [ACC_WIDTH-1:0]           sum
);
  logic signed [ACC_WIDTH-1:0] tot;
  // adder tree over the lane products; masked lanes add zero
  always_comb begin
    tot = '0;
    for (int i = 0; i < TILE_SIZE; i++)
      tot = tot + (mask[i] ? ACC_WIDTH'($signed(x[i]) * $signed(w[i])) : '0);
  end
  // pipeline register for the tile sum and its valid flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum <= '0;
    end else begin
      out_valid <= in_valid;
      sum <= tot;
    end
endmodule

// File: rtl/gemv_stream.sv
// gemv_stream: streaming int GEMV y[r] = sat((W[r].x + bias[r]) >>> shift); define GEMV_STREAM_RELU_EN to clamp negatives to 0
module gemv_stream
  import gemv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_ROWS = 128,
  parameter int MAX_COLS = 128,
  parameter int TILE_SIZE = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [$clog2(MAX_ROWS+1)-1:0]         rows_cfg,
  input  logic [$clog2(MAX_COLS+1)-1:0]         cols_cfg,
  input  logic [4:0]                            shift_cfg,
  input  logic                                  x_valid,
  output logic                                  x_ready,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  x_data,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  w_data,
  input  logic signed [ACC_WIDTH-1:0]           w_bias,
  output logic                                  y_valid,
  input  logic                                  y_ready,
  output logic [DATA_WIDTH-1:0]                 y_data,
  output logic                                  y_last,
  output logic                                  busy,
  output logic                                  done
);
  localparam int RW = $clog2(MAX_ROWS + 1);
  localparam int CW = $clog2(MAX_COLS + 1);
  localparam int NT = MAX_COLS / TILE_SIZE;
  localparam int TW = $clog2(NT + 1);
  localparam int XW = NT > 1 ? $clog2(NT) : 1;
  state_t state_q, state_d;
  logic [RW-1:0] rows_q, row_q;
  logic [CW-1:0] cols_q;
  logic [4:0] shift_q;
  logic [TW-1:0] tiles_q, tile_q;
  logic signed [ACC_WIDTH-1:0] acc_q, bias_q, dot_sum, acc_nx;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] xbuf [NT];
  logic [TILE_SIZE-1:0] mask;
  logic dot_valid, pend_q, cfg_ok, x_hs, w_hs, y_hs, last_tile, last_row, unused_hi;
  logic signed [63:0] r_full;
  logic [DATA_WIDTH-1:0] r_out;
  assign cfg_ok = rows_cfg != '0 && int'(rows_cfg) <= MAX_ROWS && cols_cfg != '0 && int'(cols_cfg) <= MAX_COLS;
  assign x_ready = state_q == LOAD_X;
  assign w_ready = state_q == STREAM_W;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign x_hs = x_valid && x_ready;
  assign w_hs = w_valid && w_ready;
  assign y_hs = y_valid && y_ready;
  assign last_tile = tile_q == tiles_q - 1'b1;
  assign last_row = row_q == rows_q - 1'b1;
  assign acc_nx = acc_q + dot_sum;
  assign r_full = sat_rshift(64'(acc_nx) + 64'(bias_q), shift_q, DATA_WIDTH);
  assign unused_hi = ^r_full[63:DATA_WIDTH];
`ifdef GEMV_STREAM_RELU_EN
  assign r_out = r_full[63] ? '0 : r_full[DATA_WIDTH-1:0];
`else
  assign r_out = r_full[DATA_WIDTH-1:0];
`endif
  // lanes past the configured column count contribute nothing
  always_comb begin
    mask = '0;
    for (int i = 0; i < TILE_SIZE; i++)
      mask[i] = int'(tile_q) * TILE_SIZE + i < int'(cols_q);
  end
  gemv_tile_dot #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .TILE_SIZE(TILE_SIZE)) u_dot (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(w_hs),
    .x(xbuf[tile_q[XW-1:0]]),
    .w(w_data),
    .mask(mask),
    .out_valid(dot_valid),
    .sum(dot_sum)
  );
  // x buffer has no reset: every tile is written in LOAD_X before it is read
  always_ff @(posedge clk)
    if (x_hs) xbuf[tile_q[XW-1:0]] <= x_data;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next-state logic; the last w beat moves straight to WAIT_Y so no new row is accepted early
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start && cfg_ok) state_d = LOAD_X;
      LOAD_X:   if (x_hs && last_tile) state_d = STREAM_W;
      STREAM_W: if (w_hs && last_tile) state_d = WAIT_Y;
      WAIT_Y:   if (y_hs) state_d = last_row ? DONE : STREAM_W;
      default:  state_d = IDLE;
    endcase
  end
  // config latch, tile/row counters, accumulator and result register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rows_q <= '0;
      cols_q <= '0;
      shift_q <= '0;
      tiles_q <= '0;
      tile_q <= '0;
      row_q <= '0;
      acc_q <= '0;
      bias_q <= '0;
      pend_q <= 1'b0;
      y_valid <= 1'b0;
      y_last <= 1'b0;
      y_data <= '0;
    end else begin
      if (state_q == IDLE && start && cfg_ok) begin
        rows_q <= rows_cfg;
        cols_q <= cols_cfg;
        shift_q <= shift_cfg;
        tiles_q <= TW'((int'(cols_cfg) + TILE_SIZE - 1) / TILE_SIZE);
        tile_q <= '0;
        row_q <= '0;
        acc_q <= '0;
      end
      if (x_hs || w_hs) tile_q <= last_tile ? '0 : tile_q + 1'b1;
      if (w_hs && tile_q == '0) bias_q <= w_bias;
      if (w_hs && last_tile) pend_q <= 1'b1;
      if (dot_valid) acc_q <= acc_nx;
      if (pend_q) begin
        pend_q <= 1'b0;
        y_valid <= 1'b1;
        y_data <= r_out;
        y_last <= last_row;
      end
      if (y_hs) begin
        y_valid <= 1'b0;
        y_last <= 1'b0;
        acc_q <= '0;
        row_q <= row_q + 1'b1;
      end
    end
endmodule
